alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue stage that drives alu_n's operand0/operand1/alu_op interface.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC instructions into the ALU op codes.
- Selects operands from register-file read data, with writeback forwarding, or from immediates/PC.
- Presents the result through a valid/ready pipeline register backed by a one-entry skid buffer, so that inst_ready_o is a registered output.

Parameters:
- n, 32, datapath width of operands and PC.
- AW, 5, register address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- inst_i  in  32  instruction word.
- pc_i  in  n  PC of inst_i.
- inst_valid_i  in  1  inst_i/pc_i valid.
- inst_ready_o  out  1  block can accept; registered.
- rs1_addr_o  out  AW  combinational inst_i[19:15] to register file.
- rs2_addr_o  out  AW  combinational inst_i[24:20] to register file.
- rs1_data_i  in  n  register file read data for rs1, same cycle.
- rs2_data_i  in  n  register file read data for rs2, same cycle.
- wb_en_i  in  1  writeback write enable.
- wb_addr_i  in  AW  writeback destination.
- wb_data_i  in  n  writeback data.
- issue_valid_o  out  1  operands/op valid toward the ALU.
- issue_ready_i  in  1  ALU stage accepts.
- operand0_o  out  n  ALU operand 0.
- operand1_o  out  n  ALU operand 1.
- alu_op_o  out  4  ALU op code.
- rd_addr_o  out  AW  destination register.
- illegal_o  out  1  one-cycle pulse: an unsupported instruction was consumed.

Behaviour:
- Reset (async, rst_ni=0) values:
  - issue_valid_o=0, inst_ready_o=1, illegal_o=0.
  - operand0_o, operand1_o, alu_op_o, rd_addr_o all 0.
  - Skid buffer empty; state EMPTY.
- Accept: an instruction is accepted when inst_valid_i & inst_ready_o at the clock edge. Operands are sampled once, at acceptance.
- Register operand value:
  - Register 0 reads as 0.
  - Else, if wb_en_i and wb_addr_i equals the source register, the value is wb_data_i (forwarding).
  - Else, the value is rs*_data_i.
- Decode of inst_i[6:0]:
  - 0110011 (OP): operand0=rs1, operand1=rs2.
    - funct3 0: op 0x0 (funct7 0x00) or 0x8 (funct7 0x20).
    - funct3 1/2/3/4/6/7: op 0x1/0x2/0x3/0x4/0x6/0x7.
    - funct3 5: op 0x5 (funct7 0x00) or 0xD (funct7 0x20).
    - Any other funct7/funct3 combination is illegal.
  - 0010011 (OP-IMM): operand0=rs1, operand1=sign-extended imm[31:20].
    - funct3 mapping as for OP, except funct3 0 is always 0x0.
    - funct3 1: funct7 must be 0x00; operand1 = zero-extended shamt[24:20].
    - funct3 5: funct7 0x00 gives 0x5, 0x20 gives 0xD; operand1 = zero-extended shamt; other funct7 is illegal.
  - 0110111 (LUI): operand0=0, operand1={inst[31:12],12'b0}, op 0x0.
  - 0010111 (AUIPC): operand0=pc_i, operand1={inst[31:12],12'b0}, op 0x0.
  - All other opcodes are illegal.
- Illegal instructions:
  - Consumed: the handshake completes, but nothing enters the pipeline.
  - illegal_o=1 for exactly the cycle after acceptance.
- Pipeline states:
  - EMPTY: issue_valid_o=0, skid empty.
    - Legal accept -> ONE; the entry is loaded into the output register.
  - ONE: issue_valid_o=1, skid empty.
    - Output fire and accept -> ONE; the output register is reloaded.
    - Output fire only -> EMPTY.
    - Accept without fire -> TWO; the entry goes to skid and inst_ready_o falls next cycle.
  - TWO: issue_valid_o=1, skid full, inst_ready_o=0.
    - Output fire -> ONE; skid moves to the output register and inst_ready_o rises next cycle.
- Latency: accept to issue_valid_o is 1 cycle from EMPTY.
- Stability: while issue_valid_o & ~issue_ready_i, every output except illegal_o holds stable.
- Ordering: no instruction is dropped or reordered.
- Hazards: RAW hazards beyond same-cycle forwarding are the upstream scoreboard's responsibility.
- Arithmetic: all immediates are extended to n bits; there are no width-dependent exceptions.
- Reset mid-operation: both entries are discarded immediately; the block is back in EMPTY on the first edge after release.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 -> next cycle issue_valid_o=1, op 0x0, operands 5/7, rd_addr_o=3.
- sub 0x402081B3 -> op 0x8. srai x5,x6,4 (0x40435293) -> op 0xD, operand1=4, rd 5.
- lui x1,0x12345 (0x123450B7) -> operand0=0, operand1=0x12345000. auipc with pc_i=0x100 -> operand0=0x100.
- Forwarding: add with wb_en_i=1, wb_addr_i=1, wb_data_i=0xAA, rs1_data_i=0 -> operand0=0xAA. Same with rs1=x0 -> operand0=0.
- Backpressure: hold issue_ready_i=0 and send 3 instructions.
  - Two are accepted; inst_ready_o=0; outputs stay stable.
  - Release -> instructions issue in order, one per cycle, and inst_ready_o returns to 1.
- Illegal instruction 0x0000006F -> accepted, illegal_o pulses 1 cycle, issue_valid_o stays 0.
- Assert rst_ni in state TWO -> outputs go to reset values immediately and nothing issues after release.

Source files
------------

// File: rtl/alu_issue_if.sv
// Issue bus from alu_issue toward the ALU stage: valid/ready handshake plus
// operands, op code and destination register.
interface alu_issue_if #(
  parameter int n  = 32,
  parameter int AW = 5
);
  logic          issue_valid_o;
  logic          issue_ready_i;
  logic [n-1:0]  operand0_o;
  logic [n-1:0]  operand1_o;
  logic [3:0]    alu_op_o;
  logic [AW-1:0] rd_addr_o;

  modport master (
    output issue_valid_o, operand0_o, operand1_o, alu_op_o, rd_addr_o,
    input  issue_ready_i
  );

  modport slave (
    input  issue_valid_o, operand0_o, operand1_o, alu_op_o, rd_addr_o,
    output issue_ready_i
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP / OP-IMM / LUI / AUIPC issue stage: decodes, picks forwarded
// operands and hands them to the ALU through an output register plus skid.
module alu_issue #(
  parameter int n  = 32,  // must be >= 32 so immediates fit
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [31:0]   inst_i,
  input  logic [n-1:0]  pc_i,
  input  logic          inst_valid_i,
  output logic          inst_ready_o,
  output logic [AW-1:0] rs1_addr_o,
  output logic [AW-1:0] rs2_addr_o,
  input  logic [n-1:0]  rs1_data_i,
  input  logic [n-1:0]  rs2_data_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [n-1:0]  wb_data_i,
  alu_issue_if.master   issue,
  output logic          illegal_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [n-1:0]  op0;
    logic [n-1:0]  op1;
    logic [3:0]    op;
    logic [AW-1:0] rd;
  } entry_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [n-1:0] rs1_val, rs2_val, imm_i, imm_u, shamt;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7     = inst_i[31:25];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  assign imm_i = n'($signed(inst_i[31:20]));
  assign imm_u = n'($signed({inst_i[31:12], 12'b0}));
  assign shamt = n'(inst_i[24:20]);

  // x0 reads zero; a same-cycle writeback to the source wins over the regfile.
  assign rs1_val = (rs1_addr_o == '0) ? '0 :
                   (wb_en_i && wb_addr_i == rs1_addr_o) ? wb_data_i : rs1_data_i;
  assign rs2_val = (rs2_addr_o == '0) ? '0 :
                   (wb_en_i && wb_addr_i == rs2_addr_o) ? wb_data_i : rs2_data_i;

  entry_t dec;
  logic   legal;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    dec    = '0;
    legal  = 1'b0;
    dec.rd = inst_i[11:7];
    case (opcode)
      7'b0110011: begin
        dec.op0 = rs1_val;
        dec.op1 = rs2_val;
        if (funct7 == 7'h00) begin
          legal  = 1'b1;
          dec.op = {1'b0, funct3};
        end else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          legal  = 1'b1;
          dec.op = {1'b1, funct3};
        end
      end
      7'b0010011: begin
        dec.op0 = rs1_val;
        dec.op1 = imm_i;
        dec.op  = {1'b0, funct3};
        legal   = 1'b1;
        if (funct3 == 3'd1) begin
          dec.op1 = shamt;
          legal   = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          dec.op1 = shamt;
          if (funct7 == 7'h20) dec.op = 4'hD;
          else                 legal  = (funct7 == 7'h00);
        end
      end
      7'b0110111: begin
        dec.op1 = imm_u;
        legal   = 1'b1;
      end
      7'b0010111: begin
        dec.op0 = pc_i;
        dec.op1 = imm_u;
        legal   = 1'b1;
      end
      default: ;
    endcase
  end

  state_t state_q, state_d;
  entry_t out_q, out_d, skid_q;
  logic   ready_q, illegal_q, load_skid;
  logic   accept, take, fire;

  assign accept = inst_valid_i && ready_q;
  assign take   = accept && legal;
  assign fire   = (state_q != EMPTY) && issue.issue_ready_i;

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    load_skid = 1'b0;
    case (state_q)
      EMPTY: if (take) begin
        state_d = ONE;
        out_d   = dec;
      end
      ONE: begin
        if (fire && take)  out_d   = dec;
        else if (fire)     state_d = EMPTY;
        else if (take) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end
      end
      TWO: if (fire) begin
        state_d = ONE;
        out_d   = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      ready_q   <= (state_d != TWO);
      illegal_q <= accept && !legal;
    end
  end

  // NOTE: skid contents are only read in TWO, which reset cannot reach, so
  // this datapath register needs no reset.
  always_ff @(posedge clk_i) begin
    if (load_skid) skid_q <= dec;
  end

  assign inst_ready_o        = ready_q;
  assign illegal_o           = illegal_q;
  assign issue.issue_valid_o = (state_q != EMPTY);
  assign issue.operand0_o    = out_q.op0;
  assign issue.operand1_o    = out_q.op1;
  assign issue.alu_op_o      = out_q.op;
  assign issue.rd_addr_o     = out_q.rd;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed spec cases plus a randomized
// run scored against a queue-based reference model.
module tb_alu_issue;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [31:0]   inst_i;
  logic [N-1:0]  pc_i;
  logic          inst_valid_i;
  logic          inst_ready_o;
  logic [AW-1:0] rs1_addr_o, rs2_addr_o;
  logic [N-1:0]  rs1_data_i, rs2_data_i;
  logic          wb_en_i;
  logic [AW-1:0] wb_addr_i;
  logic [N-1:0]  wb_data_i;
  logic          illegal_o;

  always #5 clk = ~clk;

  alu_issue_if #(.n(N), .AW(AW)) bus ();

  alu_issue #(.n(N), .AW(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .inst_i       (inst_i),
    .pc_i         (pc_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .issue        (bus),
    .illegal_o    (illegal_o)
  );

  typedef struct {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  op;
    logic [4:0]  rd;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  bit   exp_illegal = 1'b0;

  function automatic logic [31:0] reg_val(input logic [4:0] a, input logic [31:0] d,
                                          input logic wen, input logic [4:0] wa,
                                          input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wen && wa == a) return wd;
    return d;
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] d1, input logic [31:0] d2,
                                     input logic wen, input logic [4:0] wa,
                                     input logic [31:0] wd,
                                     output bit legal, output txn_t t);
    int f3, f7;
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    legal = 1'b0;
    t.op0 = 32'd0; t.op1 = 32'd0; t.op = 4'd0; t.rd = inst[11:7];
    case (inst[6:0])
      7'h33: begin
        t.op0 = reg_val(inst[19:15], d1, wen, wa, wd);
        t.op1 = reg_val(inst[24:20], d2, wen, wa, wd);
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        t.op  = 4'(f3 + ((f7 == 32) ? 8 : 0));
      end
      7'h13: begin
        t.op0 = reg_val(inst[19:15], d1, wen, wa, wd);
        t.op1 = $signed(inst) >>> 20;
        t.op  = 4'(f3);
        if (f3 == 1 || f3 == 5) begin
          t.op1 = (inst >> 20) & 32'd31;
          legal = (f7 == 0) || (f3 == 5 && f7 == 32);
          if (f7 == 32) t.op = 4'(f3 + 8);
        end else begin
          legal = 1'b1;
        end
      end
      7'h37: begin
        t.op1 = inst & 32'hFFFF_F000;
        legal = 1'b1;
      end
      7'h17: begin
        t.op0 = pc;
        t.op1 = inst & 32'hFFFF_F000;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic r);
    inst_i = i; pc_i = p; rs1_data_i = a; rs2_data_i = b;
    inst_valid_i = v; bus.issue_ready_i = r;
  endtask

  // One clock: compare pre-edge outputs with the model, update the model at
  // the edge, then check the illegal pulse. Entered and left at a negedge.
  task automatic step(input string tag);
    bit   fire, acc, legal;
    txn_t t, f;
    checks++;
    if (bus.issue_valid_o !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL %s issue_valid got %b want %b", tag, bus.issue_valid_o, exp_q.size() > 0);
    end
    checks++;
    if (inst_ready_o !== (exp_q.size() < 2)) begin
      errors++;
      $display("FAIL %s inst_ready got %b want %b", tag, inst_ready_o, exp_q.size() < 2);
    end
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      checks++;
      if ({bus.operand0_o, bus.operand1_o, bus.alu_op_o, bus.rd_addr_o} !== {f.op0, f.op1, f.op, f.rd}) begin
        errors++;
        $display("FAIL %s outputs got %h/%h/%h/%h want %h/%h/%h/%h", tag,
                 bus.operand0_o, bus.operand1_o, bus.alu_op_o, bus.rd_addr_o,
                 f.op0, f.op1, f.op, f.rd);
      end
    end
    fire = (exp_q.size() > 0) && bus.issue_ready_i;
    acc  = inst_valid_i && (exp_q.size() < 2);
    ref_decode(inst_i, pc_i, rs1_data_i, rs2_data_i, wb_en_i, wb_addr_i, wb_data_i, legal, t);
    @(posedge clk);
    if (fire) void'(exp_q.pop_front());
    if (acc && legal) exp_q.push_back(t);
    exp_illegal = acc && !legal;
    @(negedge clk);
    checks++;
    if (illegal_o !== exp_illegal) begin
      errors++;
      $display("FAIL %s illegal got %b want %b", tag, illegal_o, exp_illegal);
    end
  endtask

  task automatic drain();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    wb_en_i = 1'b0;
    repeat (3) step("drain");
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({bus.issue_valid_o, inst_ready_o, illegal_o, bus.operand0_o, bus.operand1_o,
         bus.alu_op_o, bus.rd_addr_o} !== {1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 5'd0}) begin
      errors++;
      $display("FAIL %s reset got v%b r%b i%b %h/%h/%h/%h want v0 r1 i0 0/0/0/0", tag,
               bus.issue_valid_o, inst_ready_o, illegal_o, bus.operand0_o,
               bus.operand1_o, bus.alu_op_o, bus.rd_addr_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");
  endtask

  task automatic test_decode();
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1);
    checks++;
    if ({rs1_addr_o, rs2_addr_o} !== {5'd1, 5'd2}) begin
      errors++;
      $display("FAIL rs_addr got %0d/%0d want 1/2", rs1_addr_o, rs2_addr_o);
    end
    step("add");
    checks++;
    if ({bus.issue_valid_o, bus.operand0_o, bus.operand1_o, bus.alu_op_o, bus.rd_addr_o}
        !== {1'b1, 32'd5, 32'd7, 4'h0, 5'd3}) begin
      errors++;
      $display("FAIL add got v%b %h/%h/%h/%h want v1 5/7/0/3", bus.issue_valid_o,
               bus.operand0_o, bus.operand1_o, bus.alu_op_o, bus.rd_addr_o);
    end
    drive(32'h402081B3, 32'h0, 32'd9, 32'd4, 1'b1, 1'b1);
    step("sub");
    checks++;
    if (bus.alu_op_o !== 4'h8) begin
      errors++;
      $display("FAIL sub op got %h want 8", bus.alu_op_o);
    end
    drive(32'h40435293, 32'h0, 32'hF000_0000, 32'h1234, 1'b1, 1'b1);
    step("srai");
    checks++;
    if ({bus.alu_op_o, bus.operand1_o, bus.rd_addr_o} !== {4'hD, 32'd4, 5'd5}) begin
      errors++;
      $display("FAIL srai got %h/%h/%0d want D/4/5", bus.alu_op_o, bus.operand1_o, bus.rd_addr_o);
    end
    drive(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1);
    step("lui");
    checks++;
    if ({bus.operand0_o, bus.operand1_o, bus.alu_op_o} !== {32'd0, 32'h12345000, 4'h0}) begin
      errors++;
      $display("FAIL lui got %h/%h/%h want 0/12345000/0", bus.operand0_o, bus.operand1_o, bus.alu_op_o);
    end
    drive(32'h00001117, 32'h100, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1);
    step("auipc");
    checks++;
    if ({bus.operand0_o, bus.operand1_o} !== {32'h100, 32'h1000}) begin
      errors++;
      $display("FAIL auipc got %h/%h want 100/1000", bus.operand0_o, bus.operand1_o);
    end
    drain();
  endtask

  task automatic test_forwarding();
    drive(32'h002081B3, 32'h0, 32'd0, 32'd7, 1'b1, 1'b1);
    wb_en_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'hAA;
    step("fwd_rs1");
    checks++;
    if (bus.operand0_o !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_rs1 operand0 got %h want aa", bus.operand0_o);
    end
    drive(32'h002001B3, 32'h0, 32'h55, 32'd7, 1'b1, 1'b1);
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hAA;
    step("fwd_x0");
    checks++;
    if (bus.operand0_o !== 32'd0) begin
      errors++;
      $display("FAIL fwd_x0 operand0 got %h want 0", bus.operand0_o);
    end
    wb_en_i = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] snap0, snap1;
    logic [3:0]  snapop;
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
    step("bp1");
    drive(32'h402081B3, 32'h0, 32'd3, 32'd4, 1'b1, 1'b0);
    step("bp2");
    drive(32'h00B50533, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0);
    step("bp3");
    checks++;
    if ({inst_ready_o, bus.issue_valid_o} !== 2'b01) begin
      errors++;
      $display("FAIL bp_full ready/valid got %b%b want 01", inst_ready_o, bus.issue_valid_o);
    end
    snap0 = bus.operand0_o; snap1 = bus.operand1_o; snapop = bus.alu_op_o;
    drive(32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    step("bp_hold");
    checks++;
    if ({bus.operand0_o, bus.operand1_o, bus.alu_op_o, inst_ready_o} !== {32'd1, 32'd2, 4'h0, 1'b0}
        || {snap0, snap1, snapop} !== {32'd1, 32'd2, 4'h0}) begin
      errors++;
      $display("FAIL bp_stable got %h/%h/%h r%b want 1/2/0 r0", bus.operand0_o,
               bus.operand1_o, bus.alu_op_o, inst_ready_o);
    end
    bus.issue_ready_i = 1'b1;
    step("bp_rel1");
    checks++;
    if ({inst_ready_o, bus.issue_valid_o, bus.alu_op_o, bus.operand0_o} !== {1'b1, 1'b1, 4'h8, 32'd3}) begin
      errors++;
      $display("FAIL bp_release got r%b v%b op%h %h want r1 v1 op8 3", inst_ready_o,
               bus.issue_valid_o, bus.alu_op_o, bus.operand0_o);
    end
    step("bp_rel2");
    checks++;
    if (bus.issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained valid got %b want 0", bus.issue_valid_o);
    end
    drain();
  endtask

  task automatic test_illegal();
    drive(32'h0000006F, 32'h0, 32'd0, 32'd0, 1'b1, 1'b1);
    step("illegal");
    checks++;
    if ({illegal_o, bus.issue_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL illegal pulse/valid got %b%b want 10", illegal_o, bus.issue_valid_o);
    end
    drive(32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    step("illegal_end");
    checks++;
    if (illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_len got %b want 0", illegal_o);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
    step("rm1");
    drive(32'h00B50533, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0);
    step("rm2");
    drive(32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    exp_q.delete();
    exp_illegal = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) step("after_reset");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int c = 0; c < 600; c++) begin
      ins = $urandom;
      case ($urandom_range(0, 6))
        0, 1: ins[6:0] = 7'h33;
        2, 3: ins[6:0] = 7'h13;
        4:    ins[6:0] = 7'h37;
        5:    ins[6:0] = 7'h17;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 4) == 0) ins[19:15] = 5'd0;
      drive(ins, $urandom, $urandom, $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      wb_en_i   = $urandom_range(0, 1);
      wb_addr_i = ($urandom_range(0, 1) != 0) ? ins[19:15] : ins[24:20];
      wb_data_i = $urandom;
      step("random");
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_forwarding();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
